// File: rtl/psum_bank_rotator.sv
// Partial-sum bank rotator: NUM_PEC+1 dual-port banks whose logical mapping rotates every frame.
// Optional PSUM_STALL_CNT_EN adds a saturating stall-cycle counter output (stall_cnt).
module psum_bank_rotator #(
  parameter int unsigned NUM_PEC    = 3,
  parameter int unsigned PSUM_WIDTH = 24,
  parameter int unsigned DEPTH_BIT  = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ctr_frt_frm,
  input  logic                              ctr_fnh_frm,
  output logic                              peb_stall,
  input  logic [NUM_PEC-1:0]                pec_en_wr,
  input  logic [NUM_PEC*DEPTH_BIT-1:0]      pec_addr_wr,
  input  logic [NUM_PEC*PSUM_WIDTH-1:0]     pec_dat_wr,
  input  logic [NUM_PEC-1:0]                pec_en_rd,
  input  logic [NUM_PEC*DEPTH_BIT-1:0]      pec_addr_rd,
  output logic [NUM_PEC*PSUM_WIDTH-1:0]     pec_dat_rd,
  output logic                              drain_vld,
  input  logic                              pool_en_rd,
  input  logic [DEPTH_BIT-1:0]              pool_addr_rd,
  output logic [PSUM_WIDTH-1:0]             pool_dat,
  input  logic                              pool_done,
  output logic [$clog2(NUM_PEC+1)-1:0]      base_ptr
`ifdef PSUM_STALL_CNT_EN
  ,
  output logic [15:0]                       stall_cnt
`endif
);

  localparam int unsigned NBANK = NUM_PEC + 1;
  localparam int unsigned PTR_W = $clog2(NBANK);
  localparam int unsigned DEPTH = 1 << DEPTH_BIT;

  typedef enum logic [1:0] {RUN, DRAIN, STALL} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   base_d;

  // Logical slot k -> physical bank, (base + k) mod NBANK.
  function automatic logic [PTR_W-1:0] map_bank(input logic [PTR_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NBANK) s = s - NBANK;
    return PTR_W'(s);
  endfunction

  // Frame handshake FSM and rotation of the base pointer.
  always_comb begin
    state_d = state_q;
    base_d  = base_ptr;
    unique case (state_q)
      RUN: begin
        if (ctr_fnh_frm) begin
          base_d  = (base_ptr == '0) ? PTR_W'(NUM_PEC) : base_ptr - PTR_W'(1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ctr_fnh_frm && pool_done) begin
          base_d = (base_ptr == '0) ? PTR_W'(NUM_PEC) : base_ptr - PTR_W'(1);
        end else if (ctr_fnh_frm) begin
          state_d = STALL;
        end else if (pool_done) begin
          state_d = RUN;
        end
      end
      STALL: begin
        if (pool_done) begin
          base_d  = (base_ptr == '0) ? PTR_W'(NUM_PEC) : base_ptr - PTR_W'(1);
          state_d = DRAIN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      base_ptr  <= '0;
      drain_vld <= 1'b0;
      peb_stall <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_ptr  <= base_d;
      drain_vld <= (state_d != RUN);
      peb_stall <= (state_d == STALL);
    end
  end

  // Per-bank port routing; the mapping is a bijection so each bank has at most one owner.
  logic [PTR_W-1:0]      pec_bank [NUM_PEC];
  logic [NUM_PEC-1:0]    pec_rd_eff;
  logic                  pool_rd_eff;
  logic [PTR_W-1:0]      drain_bank;
  logic                  bwr_en   [NBANK];
  logic [DEPTH_BIT-1:0]  bwr_addr [NBANK];
  logic [PSUM_WIDTH-1:0] bwr_dat  [NBANK];
  logic                  brd_en   [NBANK];
  logic [DEPTH_BIT-1:0]  brd_addr [NBANK];

  always_comb begin
    for (int b = 0; b < int'(NBANK); b++) begin
      bwr_en[b]   = 1'b0;
      bwr_addr[b] = '0;
      bwr_dat[b]  = '0;
      brd_en[b]   = 1'b0;
      brd_addr[b] = '0;
    end
    pec_rd_eff  = pec_en_rd & {NUM_PEC{~peb_stall}};
    pool_rd_eff = pool_en_rd & drain_vld;
    drain_bank  = map_bank(base_ptr, NUM_PEC);
    for (int k = 0; k < int'(NUM_PEC); k++) begin
      pec_bank[k] = map_bank(base_ptr, k);
      bwr_en[pec_bank[k]]   = pec_en_wr[k] & ~peb_stall;
      bwr_addr[pec_bank[k]] = pec_addr_wr[k*DEPTH_BIT +: DEPTH_BIT];
      bwr_dat[pec_bank[k]]  = pec_dat_wr[k*PSUM_WIDTH +: PSUM_WIDTH];
      brd_en[pec_bank[k]]   = pec_rd_eff[k];
      brd_addr[pec_bank[k]] = pec_addr_rd[k*DEPTH_BIT +: DEPTH_BIT];
    end
    brd_en[drain_bank]   = pool_rd_eff;
    brd_addr[drain_bank] = pool_addr_rd;
  end

  // Bank storage: not reset, read port registered like a synchronous SRAM.
  logic [PSUM_WIDTH-1:0] mem    [NBANK][DEPTH];
  logic [PSUM_WIDTH-1:0] bank_q [NBANK];

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(NBANK); b++) begin
      if (bwr_en[b]) mem[b][bwr_addr[b]] <= bwr_dat[b];
      if (brd_en[b]) bank_q[b] <= mem[b][brd_addr[b]];
    end
  end

  // Return-path select and zero/valid flags captured with the request.
  logic [PTR_W-1:0]   sel_q [NUM_PEC];
  logic [NUM_PEC-1:0] live_q;
  logic [PTR_W-1:0]   pool_sel_q;
  logic               pool_live_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_PEC); k++) sel_q[k] <= '0;
      live_q      <= '0;
      pool_sel_q  <= '0;
      pool_live_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUM_PEC); k++) begin
        if (pec_rd_eff[k]) sel_q[k] <= pec_bank[k];
        live_q[k] <= pec_rd_eff[k] & ~ctr_frt_frm & (k != 0);
      end
      if (pool_rd_eff) pool_sel_q <= drain_bank;
      pool_live_q <= pool_rd_eff;
    end
  end

  always_comb begin
    pec_dat_rd = '0;
    for (int k = 0; k < int'(NUM_PEC); k++) begin
      if (live_q[k]) pec_dat_rd[k*PSUM_WIDTH +: PSUM_WIDTH] = bank_q[sel_q[k]];
    end
    pool_dat = pool_live_q ? bank_q[pool_sel_q] : '0;
  end

`ifdef PSUM_STALL_CNT_EN
  // Saturating count of stalled cycles, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (peb_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_psum_bank_rotator.sv
// Directed bench for psum_bank_rotator: mapping, drain, zero forcing, stall, wrap and reset.
module tb_psum_bank_rotator;

  localparam int unsigned NP = 3;
  localparam int unsigned W  = 24;
  localparam int unsigned DB = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ctr_frt_frm, ctr_fnh_frm, peb_stall;
  logic [NP-1:0]     pec_en_wr, pec_en_rd;
  logic [NP*DB-1:0]  pec_addr_wr, pec_addr_rd;
  logic [NP*W-1:0]   pec_dat_wr, pec_dat_rd;
  logic              drain_vld, pool_en_rd, pool_done;
  logic [DB-1:0]     pool_addr_rd;
  logic [W-1:0]      pool_dat;
  logic [1:0]        base_ptr;
`ifdef PSUM_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  psum_bank_rotator #(.NUM_PEC(NP), .PSUM_WIDTH(W), .DEPTH_BIT(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctr_frt_frm(ctr_frt_frm), .ctr_fnh_frm(ctr_fnh_frm), .peb_stall(peb_stall),
    .pec_en_wr(pec_en_wr), .pec_addr_wr(pec_addr_wr), .pec_dat_wr(pec_dat_wr),
    .pec_en_rd(pec_en_rd), .pec_addr_rd(pec_addr_rd), .pec_dat_rd(pec_dat_rd),
    .drain_vld(drain_vld), .pool_en_rd(pool_en_rd), .pool_addr_rd(pool_addr_rd),
    .pool_dat(pool_dat), .pool_done(pool_done), .base_ptr(base_ptr)
`ifdef PSUM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ctr_fnh_frm = 1'b0; pec_en_wr = '0; pec_en_rd = '0; pool_en_rd = 1'b0; pool_done = 1'b0;
  endtask

  task automatic pec_write(input int k, input logic [DB-1:0] a, input logic [W-1:0] d);
    pec_en_wr[k] = 1'b1;
    pec_addr_wr[k*DB +: DB] = a;
    pec_dat_wr[k*W +: W] = d;
    tick();
    idle_in();
  endtask

  task automatic pec_read(input int k, input logic [DB-1:0] a);
    pec_en_rd[k] = 1'b1;
    pec_addr_rd[k*DB +: DB] = a;
    tick();
    idle_in();
  endtask

  task automatic pool_read(input logic [DB-1:0] a);
    pool_en_rd = 1'b1;
    pool_addr_rd = a;
    tick();
    idle_in();
  endtask

  task automatic pulse_fnh(input logic with_done);
    ctr_fnh_frm = 1'b1;
    pool_done = with_done;
    tick();
    idle_in();
  endtask

  initial begin
    rst_n = 1'b0; ctr_frt_frm = 1'b0; pec_addr_wr = '0; pec_dat_wr = '0;
    pec_addr_rd = '0; pool_addr_rd = '0;
    idle_in();
    repeat (2) tick();
    chk("rst_base", base_ptr, 0);
    chk("rst_drain", drain_vld, 0);
    chk("rst_stall", peb_stall, 0);
    chk("rst_pecdat", {8'h0, pec_dat_rd[W-1:0]} | pec_dat_rd[NP*W-1:W], 0);
    chk("rst_pool", pool_dat, 0);
    rst_n = 1'b1;
    tick();

    // Mapping: PEC1 (bank1) writes, rotate, PEC2 now owns bank1
    pec_write(1, 10'd5, 24'h000123);
    pulse_fnh(1'b0);
    chk("rot1_base", base_ptr, 3);
    chk("rot1_drain", drain_vld, 1);
    chk("rot1_stall", peb_stall, 0);
    pec_en_rd[0] = 1'b1; pec_addr_rd[0 +: DB] = 10'd5;
    pec_read(2, 10'd5);
    chk("map_pec2", pec_dat_rd[2*W +: W], 24'h000123);
    chk("map_pec0_zero", pec_dat_rd[0 +: W], 0);

    // Drain release, then illegal handshakes in RUN
    pool_done = 1'b1; tick(); idle_in();
    chk("done_drain", drain_vld, 0);
    pool_done = 1'b1; tick(); idle_in();
    chk("run_done_drain", drain_vld, 0);
    chk("run_done_base", base_ptr, 3);
    pool_read(10'd5);
    chk("run_pool_zero", pool_dat, 0);

    // Drain: PEC2 (bank1) writes, rotate, pooling reads bank1
    pec_write(2, 10'd7, 24'hABCDEF);
    pulse_fnh(1'b0);
    chk("drain_vld", drain_vld, 1);
    chk("drain_base", base_ptr, 2);
    pool_read(10'd7);
    chk("pool_dat", pool_dat, 24'hABCDEF);

    // Zero forcing: PEC1 -> bank3, PEC0 -> bank2 at base 2
    pec_write(1, 10'd9, 24'h555555);
    pec_read(1, 10'd9);
    chk("pec1_norm", pec_dat_rd[1*W +: W], 24'h555555);
    ctr_frt_frm = 1'b1;
    pec_read(1, 10'd9);
    chk("pec1_frt_zero", pec_dat_rd[1*W +: W], 0);
    ctr_frt_frm = 1'b0;
    pec_write(0, 10'd9, 24'h777777);
    pec_read(0, 10'd9);
    chk("pec0_zero", pec_dat_rd[0 +: W], 0);
    pec_write(1, 10'd11, 24'h111111);

    // Stall: fnh in DRAIN, pool_done ten cycles later
    pulse_fnh(1'b0);
    chk("stall_on", peb_stall, 1);
    chk("stall_base", base_ptr, 2);
    chk("stall_drain", drain_vld, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        pec_en_wr[1] = 1'b1; pec_addr_wr[1*DB +: DB] = 10'd11; pec_dat_wr[1*W +: W] = 24'hBADBAD;
      end
      if (i == 4) ctr_fnh_frm = 1'b1;
      tick();
      idle_in();
    end
    chk("stall_hold", peb_stall, 1);
    chk("stall_base_hold", base_ptr, 2);
    pool_done = 1'b1; tick(); idle_in();
    chk("stall_off", peb_stall, 0);
    chk("stall_rot_base", base_ptr, 1);
    chk("stall_rot_drain", drain_vld, 1);
`ifdef PSUM_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 10);
`endif
    pec_read(2, 10'd11);
    chk("stall_wr_masked", pec_dat_rd[2*W +: W], 24'h111111);

    // Simultaneous fnh and pool_done in DRAIN
    pulse_fnh(1'b1);
    chk("sim_base", base_ptr, 0);
    chk("sim_drain", drain_vld, 1);
    chk("sim_stall", peb_stall, 0);

    // Wrap: four rotations return to base 0
    for (int i = 1; i <= 4; i++) begin
      pulse_fnh(1'b1);
      chk("wrap_base", base_ptr, 32'((4 - i) % 4));
    end

    // Async reset while stalled
    pulse_fnh(1'b1);
    pulse_fnh(1'b0);
    chk("pre_rst_stall", peb_stall, 1);
    chk("pre_rst_base", base_ptr, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", peb_stall, 0);
    chk("mid_rst_drain", drain_vld, 0);
    chk("mid_rst_base", base_ptr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
